// File: rtl/arbitro_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_rr_sched
// Purpose  : Weighted round-robin scheduler moving words from four input
//            FIFOs to four output FIFOs. One input port is granted at a time.
//            The granted port is popped for up to BURST words. Each word is
//            steered to the output FIFO named by its 2-bit destination field.
//            A stall timer releases a grant that has been blocked by output
//            back-pressure for STALL_MAX cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 : clock, all logic on the rising edge
//   reset_L             : synchronous reset, active low
//   empty_p0..3         : input FIFO empty flags
//   data_in_0..3        : input FIFO head words (first-word-fall-through)
//   almostfull_p0..3    : output FIFO almost-full flags
//   pop_p0..3           : input FIFO pop strobes (combinational)
//   push_p0..3          : output FIFO push strobes (registered)
//   data_out_0..3       : output FIFO write data (registered)
//   grant               : current / last granted input port (registered)
//   idle                : scheduler idle with every input FIFO empty
// ============================================================================
module arbitro_rr_sched #(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int DEST_LSB       = 8,
    parameter int BURST          = 4,
    parameter int STALL_MAX      = 8
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      empty_p0,
    input  logic                      empty_p1,
    input  logic                      empty_p2,
    input  logic                      empty_p3,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_0,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_1,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_2,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_3,
    input  logic                      almostfull_p0,
    input  logic                      almostfull_p1,
    input  logic                      almostfull_p2,
    input  logic                      almostfull_p3,
    output logic                      pop_p0,
    output logic                      pop_p1,
    output logic                      pop_p2,
    output logic                      pop_p3,
    output logic                      push_p0,
    output logic                      push_p1,
    output logic                      push_p2,
    output logic                      push_p3,
    output logic [FIFO_WORD_SIZE-1:0] data_out_0,
    output logic [FIFO_WORD_SIZE-1:0] data_out_1,
    output logic [FIFO_WORD_SIZE-1:0] data_out_2,
    output logic [FIFO_WORD_SIZE-1:0] data_out_3,
    output logic [1:0]                grant,
    output logic                      idle
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_SERVE    = 1'b1;
    localparam logic [3:0] BURST_LAST = 4'(BURST - 1);
    localparam logic [3:0] STALL_LAST = 4'(STALL_MAX - 1);

    logic [3:0]                w_empty;
    logic [3:0]                w_afull;
    logic [FIFO_WORD_SIZE-1:0] w_data_in [4];

    assign w_empty      = {empty_p3, empty_p2, empty_p1, empty_p0};
    assign w_afull      = {almostfull_p3, almostfull_p2, almostfull_p1, almostfull_p0};
    assign w_data_in[0] = data_in_0;
    assign w_data_in[1] = data_in_1;
    assign w_data_in[2] = data_in_2;
    assign w_data_in[3] = data_in_3;

    logic [0:0] state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic [3:0] stall_cnt_q, stall_cnt_d;

    logic [FIFO_WORD_SIZE-1:0] w_head;
    logic [1:0]                w_dest;
    logic                      w_head_vld;
    logic                      w_pop;
    logic                      w_stall;

    assign w_head     = w_data_in[grant_q];
    assign w_dest     = w_head[DEST_LSB +: 2];
    assign w_head_vld = !w_empty[grant_q];
    // Pops are qualified with reset_L so nothing leaves a FIFO while in reset.
    assign w_pop      = reset_L && (state_q == S_SERVE) && w_head_vld && !w_afull[w_dest];
    assign w_stall    = reset_L && (state_q == S_SERVE) && w_head_vld &&  w_afull[w_dest];

    // Round-robin pick: scan grant+1 .. grant+4 (the last wraps back onto grant).
    logic [1:0] w_rr_sel;
    logic       w_any_req;
    always_comb begin
        w_rr_sel  = grant_q;
        w_any_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_any_req && !w_empty[grant_q + 2'(k)]) begin
                w_rr_sel  = grant_q + 2'(k);
                w_any_req = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'd3;
            burst_cnt_q <= 4'd0;
            stall_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_any_req) begin
                    state_d     = S_SERVE;
                    grant_d     = w_rr_sel;
                    burst_cnt_d = 4'd0;
                    stall_cnt_d = 4'd0;
                end
            end
            S_SERVE: begin
                if (w_pop) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    stall_cnt_d = 4'd0;
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d = S_IDLE;
                    end
                end else if (w_stall) begin
                    stall_cnt_d = stall_cnt_q + 4'd1;
                    if (stall_cnt_q == STALL_LAST) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    // Neither pop nor stall: the granted FIFO has run dry.
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pop_p0 = w_pop && (grant_q == 2'd0);
        pop_p1 = w_pop && (grant_q == 2'd1);
        pop_p2 = w_pop && (grant_q == 2'd2);
        pop_p3 = w_pop && (grant_q == 2'd3);
        idle   = (state_q == S_IDLE) && (&w_empty);
    end

    // Push path: one cycle behind the pop, word passed through untouched.
    logic [3:0]                push_q, push_d;
    logic [FIFO_WORD_SIZE-1:0] dout_q [4];

    always_comb begin
        push_d = w_pop ? (4'b0001 << w_dest) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            push_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            push_q <= push_d;
            if (w_pop) begin
                dout_q[w_dest] <= w_head;
            end
        end
    end

    // A push registered just before reset asserts must not reach the output
    // FIFO, so the strobes are also qualified by reset_L.
    assign push_p0    = push_q[0] && reset_L;
    assign push_p1    = push_q[1] && reset_L;
    assign push_p2    = push_q[2] && reset_L;
    assign push_p3    = push_q[3] && reset_L;
    assign data_out_0 = dout_q[0];
    assign data_out_1 = dout_q[1];
    assign data_out_2 = dout_q[2];
    assign data_out_3 = dout_q[3];
    assign grant      = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_rr_sched
// Purpose  : Self-checking bench for arbitro_rr_sched. Input FIFOs are
//            modelled as queues; each test record lists FIFO contents,
//            back-pressure and the expected per-cycle pop port. Popped words
//            go to a scoreboard checked against push/data_out one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_rr_sched;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [3:0] emp;
    logic [3:0] afl;
    logic [9:0] din [4];

    wire        pop0, pop1, pop2, pop3;
    wire        push0, push1, push2, push3;
    wire  [9:0] do0, do1, do2, do3;
    wire  [1:0] grant;
    wire        idle;

    always #5 clk = ~clk;

    arbitro_rr_sched #(
        .FIFO_WORD_SIZE(10),
        .DEST_LSB      (8),
        .BURST         (4),
        .STALL_MAX     (8)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .empty_p0     (emp[0]),
        .empty_p1     (emp[1]),
        .empty_p2     (emp[2]),
        .empty_p3     (emp[3]),
        .data_in_0    (din[0]),
        .data_in_1    (din[1]),
        .data_in_2    (din[2]),
        .data_in_3    (din[3]),
        .almostfull_p0(afl[0]),
        .almostfull_p1(afl[1]),
        .almostfull_p2(afl[2]),
        .almostfull_p3(afl[3]),
        .pop_p0       (pop0),
        .pop_p1       (pop1),
        .pop_p2       (pop2),
        .pop_p3       (pop3),
        .push_p0      (push0),
        .push_p1      (push1),
        .push_p2      (push2),
        .push_p3      (push3),
        .data_out_0   (do0),
        .data_out_1   (do1),
        .data_out_2   (do2),
        .data_out_3   (do3),
        .grant        (grant),
        .idle         (idle)
    );

    // One test record: FIFO fill, back-pressure, expected pop port per cycle
    // after reset release (one hex digit per cycle, F = no pop).
    typedef struct packed {
        logic [3:0][3:0] cnt;     // words per input port
        logic [3:0][1:0] dst;     // destination of every word of a port
        logic [3:0]      dst_inc; // port words carry dest 0,1,2,3,...
        logic [3:0]      af;      // almostfull mask at start
        logic [7:0]      af_rel;  // cycle at which almostfull drops
        logic [7:0]      ncyc;    // cycles in trace
        logic [63:0]     trace;   // left-aligned
    } vec_t;

    typedef struct packed {
        logic       v;
        logic [1:0] d;
        logic [9:0] w;
    } sb_t;

    vec_t       tbl [5];
    sb_t        sb [$];
    logic [9:0] fifo [4][$];
    logic [9:0] exp_dout [4];
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < 4; p++) begin
            emp[p] = (fifo[p].size() == 0);
            din[p] = emp[p] ? 10'h000 : fifo[p][0];
        end
    endtask

    // One clock cycle: observe at negedge, update FIFO model after posedge.
    task automatic cycle(input int exp_pop);
        int         obs;
        int         npop;
        logic [3:0] pv;
        logic [3:0] xpush;
        sb_t        e;
        sb_t        n;
        @(negedge clk);
        pv   = {pop3, pop2, pop1, pop0};
        obs  = -1;
        npop = 0;
        for (int p = 0; p < 4; p++) begin
            if (pv[p]) begin
                npop++;
                obs = p;
            end
        end
        chk("pop_multi", 64'(npop > 1), 64'd0);
        chk("pop_port", 64'(obs), 64'(exp_pop));
        if (obs >= 0) chk("grant_vs_pop", 64'(grant), 64'(obs));
        e     = sb.pop_front();
        xpush = (e.v && reset_L) ? (4'b0001 << e.d) : 4'b0000;
        chk("push", 64'({push3, push2, push1, push0}), 64'(xpush));
        if (e.v) exp_dout[e.d] = e.w;
        chk("data_out", 64'({do3, do2, do1, do0}),
            64'({exp_dout[3], exp_dout[2], exp_dout[1], exp_dout[0]}));
        n = '0;
        if (obs >= 0) begin
            if (fifo[obs].size() == 0) begin
                chk("pop_empty", 64'd1, 64'd0);
            end else begin
                n.v = 1'b1;
                n.w = fifo[obs][0];
                n.d = n.w[9:8];
            end
        end
        sb.push_back(n);
        if (!reset_L) begin
            for (int p = 0; p < 4; p++) exp_dout[p] = 10'h000;
        end
        @(posedge clk);
        #1;
        if (n.v) void'(fifo[obs].pop_front());
        drive_inputs();
    endtask

    task automatic load(input vec_t v);
        logic [1:0] d;
        for (int p = 0; p < 4; p++) begin
            fifo[p].delete();
            for (int k = 0; k < int'(v.cnt[p]); k++) begin
                d = v.dst_inc[p] ? 2'(k) : v.dst[p];
                fifo[p].push_back({d, 2'(p), 2'b10, 4'(k)});
            end
        end
        afl = v.af;
        drive_inputs();
    endtask

    // Two reset cycles; reset-state checks after the first reset edge.
    task automatic do_reset();
        reset_L = 1'b0;
        cycle(-1);
        chk("reset_grant", 64'(grant), 64'd3);
        chk("reset_pop", 64'({pop3, pop2, pop1, pop0}), 64'd0);
        chk("reset_push", 64'({push3, push2, push1, push0}), 64'd0);
        chk("reset_dout", 64'({do3, do2, do1, do0}), 64'd0);
        cycle(-1);
        reset_L = 1'b1;
    endtask

    function automatic vec_t mkv(input logic [15:0] cnt, input logic [7:0] dst,
                                 input logic [3:0] dinc, input logic [3:0] af,
                                 input logic [7:0] af_rel, input logic [7:0] ncyc,
                                 input logic [63:0] trace);
        vec_t v;
        v.cnt     = cnt;
        v.dst     = dst;
        v.dst_inc = dinc;
        v.af      = af;
        v.af_rel  = af_rel;
        v.ncyc    = ncyc;
        v.trace   = trace;
        return v;
    endfunction

    initial begin
        int         xp;
        logic [3:0] dig;
        // round robin, 2 words dest 1 on every port
        tbl[0] = mkv(16'h2222, 8'b01010101, 4'b0000, 4'b0000, 8'd255, 8'd16, 64'hF00FF11FF22FF33F);
        // burst limit: p2 with 6 words dest 3
        tbl[1] = mkv(16'h0600, 8'b00110000, 4'b0000, 4'b0000, 8'd255, 8'd9,  64'hF2222F22FFFFFFFF);
        // back-pressure: p0 dest 2 blocked, p1 dest 0; release at cycle 12
        tbl[2] = mkv(16'h0011, 8'b00000010, 4'b0000, 4'b0100, 8'd12,  8'd15, 64'hFFFFFFFFFF1FF0FF);
        // steering: p3 words with dest 0,1,2,3
        tbl[3] = mkv(16'h4000, 8'b00000000, 4'b1000, 4'b0000, 8'd255, 8'd6,  64'hF3333FFFFFFFFFFF);
        // burst limit coincides with empty on p0, then p1
        tbl[4] = mkv(16'h0014, 8'b00000000, 4'b0000, 4'b0000, 8'd255, 8'd8,  64'hF0000F1FFFFFFFFF);

        reset_L = 1'b0;
        afl     = 4'b0000;
        for (int p = 0; p < 4; p++) exp_dout[p] = 10'h000;
        sb.push_back('0);

        for (int t = 0; t < 5; t++) begin
            load(tbl[t]);
            do_reset();
            for (int i = 0; i < int'(tbl[t].ncyc); i++) begin
                if (i == int'(tbl[t].af_rel)) begin
                    afl = 4'b0000;
                    drive_inputs();
                end
                dig = tbl[t].trace[63 - 4*i -: 4];
                xp  = (dig == 4'hF) ? -1 : int'(dig);
                cycle(xp);
            end
            cycle(-1);
            chk("idle_end", 64'(idle), 64'd1);
        end

        // Mid-burst reset: reset asserted the cycle after the first pop.
        load(mkv(16'h0040, 8'b00100000, 4'b0000, 4'b0000, 8'd255, 8'd0, 64'h0));
        do_reset();
        cycle(-1);
        cycle(1);
        reset_L = 1'b0;
        cycle(-1);
        chk("midrst_grant", 64'(grant), 64'd3);
        chk("midrst_push", 64'({push3, push2, push1, push0}), 64'd0);
        reset_L = 1'b1;
        cycle(-1);
        cycle(1);
        cycle(1);
        cycle(1);
        cycle(-1);
        cycle(-1);
        chk("midrst_idle", 64'(idle), 64'd1);
        chk("midrst_drained", 64'(fifo[1].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbitro_rr_sched.md
Name: arbitro_rr_sched

Overview:
- Weighted round-robin scheduler between 4 input FIFOs (p0..p3) and 4 output FIFOs (p0..p3) in the transaction layer.
- Grants one input port at a time and pops up to BURST words from it. Each word is steered to the output FIFO selected by its destination field.
- Back-pressure comes from the output FIFOs' almostfull flags. A stall timer releases a blocked grant so one congested destination cannot starve the others indefinitely.

Parameters:
- FIFO_WORD_SIZE, 10: word width of data_in/data_out.
- DEST_LSB, 8: LSB of 2-bit destination field; destination = word[DEST_LSB+1:DEST_LSB].
- BURST, 4: max words popped per grant (1..15).
- STALL_MAX, 8: consecutive stalled cycles before a grant is forcibly released (1..15).

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset_L  input  1  synchronous reset, active low.
- empty_p0..empty_p3  input  1 each  input FIFO empty flags.
- data_in_0..data_in_3  input  FIFO_WORD_SIZE each  head word of input FIFO (first-word-fall-through; valid when empty_pX=0).
- almostfull_p0..almostfull_p3  input  1 each  output FIFO almostfull flags (guarantee ≥1 free slot when asserted).
- pop_p0..pop_p3  output  1 each  pop strobe to input FIFO (combinational).
- push_p0..push_p3  output  1 each  push strobe to output FIFO (registered).
- data_out_0..data_out_3  output  FIFO_WORD_SIZE each  word for output FIFO (registered).
- grant  output  2  currently/last granted input port (registered).
- idle  output  1  1 when state=IDLE and all empty_pX=1 (combinational).

Behaviour:
- Reset (reset_L=0 at posedge):
  - state=IDLE, grant=3, burst_cnt=0, stall_cnt=0.
  - All push_pX=0, all data_out_X=0.
  - A push pending from the previous cycle is dropped.
  - pop_pX=0 while reset_L=0.
- States: IDLE, SERVE.
- IDLE:
  - Scan ports grant+1, grant+2, grant+3, grant (mod 4); the first with empty=0 is chosen.
  - Load grant, go to SERVE, clear both counters.
  - No pop is issued in IDLE (1-cycle selection bubble).
  - If all ports are empty, stay in IDLE.
- SERVE, with d = destination of data_in_grant:
  - pop_p[grant] = !empty_p[grant] && !almostfull_p[d]; all other pops are 0.
  - Pop cycle: burst_cnt++, stall_cnt=0.
  - Stall cycle (!empty && almostfull_p[d]): stall_cnt++.
  - Exit to IDLE at the end of the cycle when any of the following holds:
    - a pop occurs with burst_cnt==BURST-1;
    - empty_p[grant]=1;
    - a stall occurs with stall_cnt==STALL_MAX-1.
  - grant keeps its value on exit, so the round-robin pointer advances past it.
- Push path (1-cycle latency):
  - A pop in cycle t gives push_p[d]=1 and data_out_d = popped word in cycle t+1. The word is passed through unmodified.
  - Other push_pX=0; non-pushed data_out_X hold their previous value.
- Simultaneous events:
  - Burst limit and empty in the same cycle: exit once, no double action.
  - Reset has priority over everything.
- At most one pop and one push per cycle. Words from one input keep their order.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with all inputs non-empty -> all pop/push=0, data_out_*=0, grant=3; after release, first SERVE grant=0.
- Round-robin: p0..p3 each hold 2 words with dest=1 (e.g. 0x1AA), no almostfull -> grants 0,1,2,3; 8 pushes on push_p1 in that order, each 1 cycle after its pop.
- Burst limit: only p2 has 6 words (dest 3), BURST=4 -> 4 pops, 1 idle cycle, then 2 more pops; push_p3 asserted 6 times with data intact.
- Back-pressure: p0 head dest=2, almostfull_p2=1 -> no pop; after 8 stall cycles grant moves to p1 (non-empty, dest 0) and push_p0 occurs.
- Steering: p3 words with dest 0,1,2,3 consecutively -> push_p0..push_p3 pulse in successive cycles, data_out_X matches the words.
- Mid-burst reset: reset_L=0 the cycle after a pop -> the pending push is suppressed and state returns to IDLE with grant=3.
